tt_loopback_tester: RTL

- Stimulus and checker for the pad loopback path used in the multiplexer connectivity check.
- Sits on the user-tile side, opposite the harness that wires output pads back to input pads.
- Drives an LFSR pattern onto its outputs and checks the returned inputs against the expected pattern delayed by a programmable latency.
- Reports pass/fail, an error count and the index of the first mismatch.

---
 rtl/tt_loopback_tester.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tt_loopback_tester.sv
// Pad loopback stimulus/checker: drives a Galois LFSR pattern out and compares the
// returned pattern against the same sequence delayed by a latency latched at start.
module tt_loopback_tester #(
  parameter int unsigned   W       = 8,
  parameter logic [W-1:0]  TAPS    = 8'hB8,
  parameter logic [W-1:0]  SEED    = 8'h01,
  parameter int unsigned   N_VEC   = 255,
  parameter int unsigned   LAT_MAX = 15,
  parameter int unsigned   ERR_W   = 8,
  localparam int unsigned  IDX_W   = (N_VEC > 1) ? $clog2(N_VEC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       lat,
  output logic [W-1:0]     pat_out,
  input  logic [W-1:0]     pat_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] first_err_idx
);

  localparam int unsigned CYC_W = $clog2(N_VEC + LAT_MAX + 1);
  localparam int unsigned DLY_D = (LAT_MAX > 0) ? LAT_MAX : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     lfsr_q, lfsr_d;
  logic [W-1:0]     pat_out_q, pat_out_d;
  logic [3:0]       lat_q, lat_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [IDX_W-1:0] chk_idx_q, chk_idx_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [W-1:0]     dly_q [DLY_D];
  logic [W-1:0]     exp_pat;
  logic             cmp_en;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // dly_q[k] holds pat_out from k+1 cycles ago; lat=0 compares against the live output.
  always_comb begin
    if (lat_q == 4'd0) exp_pat = pat_out_q;
    else               exp_pat = dly_q[lat_q - 4'd1];
  end

  assign cmp_en = (CYC_W'(lat_q) <= cyc_q);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    pat_out_d = pat_out_q;
    lat_d     = lat_q;
    cyc_d     = cyc_q;
    chk_idx_d = chk_idx_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRun;
          lat_d     = lat;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_cnt_d = '0;
          first_d   = '0;
          chk_idx_d = '0;
          cyc_d     = '0;
          pat_out_d = SEED;
          lfsr_d    = lfsr_step(SEED);
        end
      end
      StRun: begin
        cyc_d     = cyc_q + CYC_W'(1);
        pat_out_d = (32'(cyc_q) + 32'd1 < N_VEC) ? lfsr_q : '0;
        lfsr_d    = lfsr_step(lfsr_q);
        if (cmp_en) begin
          if (pat_in != exp_pat) begin
            if (err_cnt_q == '0) first_d = chk_idx_q;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
          end
          chk_idx_d = chk_idx_q + IDX_W'(1);
          if (chk_idx_q == IDX_W'(N_VEC - 1)) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      lfsr_q    <= SEED;
      pat_out_q <= '0;
      lat_q     <= '0;
      cyc_q     <= '0;
      chk_idx_q <= '0;
      err_cnt_q <= '0;
      first_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      for (int k = 0; k < DLY_D; k++) dly_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      pat_out_q <= pat_out_d;
      lat_q     <= lat_d;
      cyc_q     <= cyc_d;
      chk_idx_q <= chk_idx_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      dly_q[0]  <= pat_out_q;
      for (int k = 1; k < DLY_D; k++) dly_q[k] <= dly_q[k-1];
    end
  end

  assign pat_out       = pat_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_q;

endmodule
